// File: rtl/aes_ctr_sched.sv
// AES CTR-mode block scheduler: one counter increment and one cipher-core handoff per block.
// Optional watchdog on the WAIT state is compiled in with AES_CTR_SCHED_WDOG_EN.
module aes_ctr_sched #(
  parameter int NumBlocksW    = 16,
  parameter int TimeoutCycles = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [NumBlocksW-1:0] num_blocks_i,
  input  logic                  abort_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  incr_o,
  input  logic                  ctr_ready_i,
  input  logic                  ctr_alert_i,
  output logic                  blk_valid_o,
  input  logic                  blk_ready_i,
  output logic [NumBlocksW-1:0] blk_idx_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_PRESENT = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [NumBlocksW-1:0] remaining_q, remaining_d;
  logic [NumBlocksW-1:0] idx_q, idx_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  done_q, done_d;

`ifdef AES_CTR_SCHED_WDOG_EN
  localparam int WdogW = $clog2(TimeoutCycles + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;

  // Watchdog counter register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  if (TimeoutCycles < 2) begin : g_timeout_unused
  end
`endif

  // Scheduler state and bookkeeping registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      idx_q        <= '0;
      abort_pend_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      idx_q        <= idx_d;
      abort_pend_q <= abort_pend_d;
      done_q       <= done_d;
    end
  end

  // Next-state logic; alert overrides every other event
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    idx_d        = idx_q;
    abort_pend_d = abort_pend_q;
    done_d       = 1'b0;
`ifdef AES_CTR_SCHED_WDOG_EN
    wdog_d       = wdog_q;
`endif
    if (ctr_alert_i) begin
      state_d = ST_ERROR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (num_blocks_i != '0) begin
              remaining_d = num_blocks_i;
              idx_d       = '0;
              state_d     = ST_REQ;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_REQ: begin
          if (abort_i) begin
            state_d = ST_IDLE;
          end else if (ctr_ready_i) begin
            state_d = ST_WAIT;
`ifdef AES_CTR_SCHED_WDOG_EN
            wdog_d  = '0;
`endif
          end else begin
            state_d = ST_REQ;
          end
        end
        ST_WAIT: begin
          // An abort here is only honoured once the counter FSM is back to idle
          if (ctr_ready_i) begin
            if (abort_pend_q || abort_i) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_PRESENT;
            end
          end else begin
            if (abort_i) begin
              abort_pend_d = 1'b1;
            end else begin
              abort_pend_d = abort_pend_q;
            end
`ifdef AES_CTR_SCHED_WDOG_EN
            if (wdog_q == WdogW'(TimeoutCycles)) begin
              state_d = ST_ERROR;
            end else begin
              wdog_d = wdog_q + WdogW'(1);
            end
`endif
          end
        end
        ST_PRESENT: begin
          if (abort_i) begin
            state_d = ST_IDLE;
          end else if (blk_ready_i) begin
            if (remaining_q == NumBlocksW'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end else begin
              remaining_d = remaining_q - NumBlocksW'(1);
              idx_d       = idx_q + NumBlocksW'(1);
              state_d     = ST_REQ;
            end
          end else begin
            state_d = ST_PRESENT;
          end
        end
        ST_ERROR: begin
          state_d = ST_ERROR;
        end
        default: begin
          state_d = ST_ERROR;
        end
      endcase
    end
    if (state_d == ST_IDLE) begin
      abort_pend_d = 1'b0;
    end else begin
      abort_pend_d = abort_pend_d;
    end
  end

  assign busy_o      = (state_q == ST_REQ) || (state_q == ST_WAIT) || (state_q == ST_PRESENT);
  assign done_o      = done_q;
  assign err_o       = (state_q == ST_ERROR);
  assign incr_o      = (state_q == ST_REQ);
  assign blk_valid_o = (state_q == ST_PRESENT);
  assign blk_idx_o   = idx_q;

endmodule
